// File: rtl/ta_update_arbiter.sv
// Bank of Tsetlin-automaton state registers with round-robin arbitration of
// saturating inc/dec requests and a sequenced bulk-load mode.
module ta_update_arbiter #(
  parameter int N_REQ      = 4,
  parameter int IDX_W      = 3,
  parameter int STATE_W    = 3,
  parameter int INIT_STATE = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*IDX_W-1:0]     req_idx,
  input  logic [N_REQ-1:0]           req_inc,
  output logic [N_REQ-1:0]           grant,
  input  logic                       load_start,
  input  logic [STATE_W-1:0]         load_value,
  output logic                       busy,
  output logic                       load_done,
  output logic [(2**IDX_W)*STATE_W-1:0] ta_state,
  output logic [(2**IDX_W)-1:0]      ta_action
);

  localparam int N_TA  = 2**IDX_W;
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, LOAD} fsm_t;

  fsm_t               state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, gsel;
  logic               gvalid;
  int                 r;
  logic [IDX_W-1:0]   tgt_idx;
  logic               tgt_inc;
  logic [IDX_W-1:0]   load_idx_q;
  logic [STATE_W-1:0] load_val_q;
  logic               load_done_q;
  logic               load_last;
  logic [STATE_W-1:0] ta_q [N_TA];

  // Saturating one-step move; the endpoints hold so repeated feedback is harmless.
  function automatic logic [STATE_W-1:0] sat_step(input logic [STATE_W-1:0] s,
                                                  input logic inc);
    if (inc)
      return (s == {STATE_W{1'b1}}) ? s : s + STATE_W'(1);
    else
      return (s == '0) ? s : s - STATE_W'(1);
  endfunction

  // Round-robin search starting at the pointer; load_start pre-empts arbitration.
  always_comb begin
    grant  = '0;
    gvalid = 1'b0;
    gsel   = '0;
    r      = 0;
    if (rst_n && state_q == IDLE && !load_start) begin
      for (int k = 0; k < N_REQ; k++) begin
        r = int'(ptr_q) + k;
        if (r >= N_REQ) r = r - N_REQ;
        if (!gvalid && req[r]) begin
          grant[r] = 1'b1;
          gvalid   = 1'b1;
          gsel     = PTR_W'(r);
        end
      end
    end
  end

  assign tgt_idx = req_idx[gsel*IDX_W +: IDX_W];
  assign tgt_inc = req_inc[gsel];

  always_comb begin
    ptr_d = ptr_q;
    if (gvalid)
      ptr_d = (gsel == PTR_W'(N_REQ-1)) ? '0 : gsel + PTR_W'(1);
  end

  assign load_last = (load_idx_q == IDX_W'(N_TA-1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (load_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      load_idx_q  <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      load_done_q <= (state_q == LOAD) && load_last;
      if (state_q == IDLE && load_start)
        load_idx_q <= '0;
      else if (state_q == LOAD)
        load_idx_q <= load_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && load_start)
      load_val_q <= load_value;
  end

  // A load owns the bank for N_TA cycles; otherwise the single granted update applies.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_TA; i++) begin
      if (!rst_n)
        ta_q[i] <= STATE_W'(INIT_STATE);
      else if (state_q == LOAD) begin
        if (load_idx_q == IDX_W'(i))
          ta_q[i] <= load_val_q;
      end else if (gvalid && tgt_idx == IDX_W'(i))
        ta_q[i] <= sat_step(ta_q[i], tgt_inc);
    end
  end

  for (genvar g = 0; g < N_TA; g++) begin : g_flat
    assign ta_state[g*STATE_W +: STATE_W] = ta_q[g];
    assign ta_action[g]                    = ta_q[g][STATE_W-1];
  end

  assign busy      = (state_q == LOAD);
  assign load_done = load_done_q;

endmodule

// File: tb/tb_ta_update_arbiter.sv
// Directed bench for ta_update_arbiter: table-driven arbitration vectors plus
// hand-written bulk-load and reset-during-load sequences.
module tb_ta_update_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] req_idx;
  logic [3:0]  req_inc;
  logic [3:0]  grant;
  logic        load_start;
  logic [2:0]  load_value;
  logic        busy;
  logic        load_done;
  logic [23:0] ta_state;
  logic [7:0]  ta_action;

  int n_chk;
  int n_fail;

  ta_update_arbiter #(
    .N_REQ(4), .IDX_W(3), .STATE_W(3), .INIT_STATE(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_idx(req_idx), .req_inc(req_inc),
    .grant(grant), .load_start(load_start), .load_value(load_value),
    .busy(busy), .load_done(load_done), .ta_state(ta_state), .ta_action(ta_action)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [11:0] idx;
    logic [3:0]  inc;
    logic [3:0]  gnt;
    int          ta;
    logic [2:0]  st;
    logic [7:0]  act;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [2:0] ta_of(input int i);
    return ta_state[i*3 +: 3];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_all_ta(input string nm, input logic [2:0] exp);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_ta%0d", nm, i), 32'(ta_of(i)), 32'(exp));
  endtask

  initial begin
    logic [2:0] old_v;
    int         done_cnt;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    req = '0; req_idx = '0; req_inc = '0;
    load_start = 1'b0; load_value = '0;

    // Single-requester increments to saturation, then reset.
    tbl.push_back('{1'b0, 4'b0010, 12'h028, 4'b0010, 4'b0010, 5, 3'd3, 8'h00, "inc_a1"});
    tbl.push_back('{1'b0, 4'b0010, 12'h028, 4'b0010, 4'b0010, 5, 3'd4, 8'h20, "inc_a2"});
    tbl.push_back('{1'b0, 4'b0010, 12'h028, 4'b0010, 4'b0010, 5, 3'd5, 8'h20, "inc_a3"});
    tbl.push_back('{1'b0, 4'b0010, 12'h028, 4'b0010, 4'b0010, 5, 3'd6, 8'h20, "inc_a4"});
    tbl.push_back('{1'b0, 4'b0010, 12'h028, 4'b0010, 4'b0010, 5, 3'd7, 8'h20, "inc_sat"});
    tbl.push_back('{1'b0, 4'b0000, 12'h028, 4'b0010, 4'b0000, 5, 3'd7, 8'h20, "inc_hold"});
    tbl.push_back('{1'b1, 4'b0000, 12'h000, 4'b0000, 4'b0000, 5, 3'd7, 8'h20, "rst1"});
    // All four requesting distinct TAs (0,1,3,4), then req[2] dropped.
    tbl.push_back('{1'b0, 4'b1111, 12'h8C8, 4'b1111, 4'b0001, 0, 3'd3, 8'h00, "rr_b1"});
    tbl.push_back('{1'b0, 4'b1111, 12'h8C8, 4'b1111, 4'b0010, 0, 3'd4, 8'h01, "rr_b2"});
    tbl.push_back('{1'b0, 4'b1111, 12'h8C8, 4'b1111, 4'b0100, 1, 3'd4, 8'h03, "rr_b3"});
    tbl.push_back('{1'b0, 4'b1111, 12'h8C8, 4'b1111, 4'b1000, 3, 3'd4, 8'h0B, "rr_b4"});
    tbl.push_back('{1'b0, 4'b1111, 12'h8C8, 4'b1111, 4'b0001, 4, 3'd4, 8'h1B, "rr_b5"});
    tbl.push_back('{1'b0, 4'b1011, 12'h8C8, 4'b1111, 4'b0010, 0, 3'd5, 8'h1B, "rr_b6"});
    tbl.push_back('{1'b0, 4'b1011, 12'h8C8, 4'b1111, 4'b1000, 1, 3'd5, 8'h1B, "rr_skip"});
    tbl.push_back('{1'b0, 4'b1011, 12'h8C8, 4'b1111, 4'b0001, 4, 3'd5, 8'h1B, "rr_b8"});
    tbl.push_back('{1'b0, 4'b0000, 12'h8C8, 4'b1111, 4'b0000, 0, 3'd6, 8'h1B, "rr_b9"});
    tbl.push_back('{1'b1, 4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 3'd6, 8'h1B, "rst2"});
    // Requesters 0 and 3 both decrementing TA2.
    tbl.push_back('{1'b0, 4'b1001, 12'h402, 4'b0000, 4'b0001, 2, 3'd3, 8'h00, "dec_c1"});
    tbl.push_back('{1'b0, 4'b1001, 12'h402, 4'b0000, 4'b1000, 2, 3'd2, 8'h00, "dec_c2"});
    tbl.push_back('{1'b0, 4'b1001, 12'h402, 4'b0000, 4'b0001, 2, 3'd1, 8'h00, "dec_c3"});
    tbl.push_back('{1'b0, 4'b1001, 12'h402, 4'b0000, 4'b1000, 2, 3'd0, 8'h00, "dec_sat"});
    tbl.push_back('{1'b0, 4'b0000, 12'h402, 4'b0000, 4'b0000, 2, 3'd0, 8'h00, "dec_hold"});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_all_ta("reset", 3'd3);
    chk("reset_action", 32'(ta_action), 32'h00);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(load_done), 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n   = ~tbl[i].rst;
      req     = tbl[i].rq;
      req_idx = tbl[i].idx;
      req_inc = tbl[i].inc;
      #1;
      chk({tbl[i].name, "_grant"}, 32'(grant), 32'(tbl[i].gnt));
      chk({tbl[i].name, "_state"}, 32'(ta_of(tbl[i].ta)), 32'(tbl[i].st));
      chk({tbl[i].name, "_action"}, 32'(ta_action), 32'(tbl[i].act));
    end

    // Bulk load of 6 with requester 0 pending on TA7; TA2 holds 0, others 3.
    done_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0001; req_idx = 12'h007; req_inc = 4'b0001;
    load_start = 1'b1; load_value = 3'd6;
    #1;
    chk("ld_start_grant", 32'(grant), 32'h0);
    chk("ld_start_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      load_start = (k == 3);
      load_value = 3'd2;
      #1;
      if (load_done) done_cnt++;
      old_v = (k == 2) ? 3'd0 : 3'd3;
      chk($sformatf("ld_busy%0d", k), 32'(busy), 32'h1);
      chk($sformatf("ld_grant%0d", k), 32'(grant), 32'h0);
      chk($sformatf("ld_pre_ta%0d", k), 32'(ta_of(k)), 32'(old_v));
      if (k > 0) chk($sformatf("ld_post_ta%0d", k-1), 32'(ta_of(k-1)), 32'h6);
    end
    @(negedge clk);
    load_start = 1'b0;
    #1;
    if (load_done) done_cnt++;
    chk("ld_end_busy", 32'(busy), 32'h0);
    chk("ld_end_done", 32'(load_done), 32'h1);
    chk("ld_resume_grant", 32'(grant), 32'h1);
    chk_all_ta("ld_end", 3'd6);
    chk("ld_end_action", 32'(ta_action), 32'hFF);
    @(negedge clk);
    req = 4'b0000;
    #1;
    if (load_done) done_cnt++;
    chk("ld_done_pulses", 32'(done_cnt), 32'h1);
    chk("ld_resume_ta7", 32'(ta_of(7)), 32'h7);
    chk("ld_after_busy", 32'(busy), 32'h0);

    // Reset during the fourth cycle of a load of value 1.
    done_cnt = 0;
    @(negedge clk);
    load_start = 1'b1; load_value = 3'd1;
    @(negedge clk);
    load_start = 1'b0;
    @(negedge clk);
    #1;
    chk("rl_ta0_loaded", 32'(ta_of(0)), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rl_busy_before", 32'(busy), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rl_busy", 32'(busy), 32'h0);
    chk("rl_grant", 32'(grant), 32'h0);
    chk_all_ta("rl", 3'd3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (load_done || busy) done_cnt++;
    end
    chk("rl_no_done", 32'(done_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ta_update_arbiter.md
Name: ta_update_arbiter

Overview:
- Owns a bank of 2**IDX_W Tsetlin-automaton state registers, each STATE_W bits wide. Action output = state MSB.
- Arbitrates saturating increment/decrement requests from N_REQ clause-feedback sources, round-robin, applying at most one update per cycle.
- Provides a sequenced bulk-load mode that writes a configured state into every automaton, one per cycle.
- Sits between the feedback logic and the clause evaluation datapath.

Parameters:
- N_REQ, 4: number of feedback requesters.
- IDX_W, 3: automaton index width. N_TA = 2**IDX_W = 8 automata.
- STATE_W, 3: automaton state width, giving 8 states.
- INIT_STATE, 3: per-automaton state value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  N_REQ  per-requester update request. Held high until granted.
- req_idx  in  N_REQ*IDX_W  target automaton index. Requester r uses bits [r*IDX_W +: IDX_W].
- req_inc  in  N_REQ  per-requester direction: 1 = increment, 0 = decrement.
- grant  out  N_REQ  one-hot, combinational. Marks the request accepted this cycle.
- load_start  in  1  single-cycle pulse that starts a bulk load.
- load_value  in  STATE_W  value written to all automata during a bulk load. Sampled on the load_start cycle.
- busy  out  1  high while the bulk load runs.
- load_done  out  1  one-cycle pulse when the bulk load completes.
- ta_state  out  N_TA*STATE_W  flattened, registered automaton states.
- ta_action  out  N_TA  MSB of each automaton state.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - every state = INIT_STATE; ta_action = 0 for the default.
  - FSM = IDLE; round-robin pointer = 0.
  - busy = 0, load_done = 0, grant = 0.
  - Reset mid-load abandons the load; automata already loaded are restored to INIT_STATE.
- FSM states: IDLE and LOAD.
- IDLE, arbitration:
  - Search order starts at the pointer and wraps modulo N_REQ. The first r with req[r] = 1 gets grant[r] = 1 in the same cycle.
  - On the next edge the granted automaton's state updates to state+1 (req_inc = 1) or state-1 (req_inc = 0).
  - Saturation: increment at 2**STATE_W-1 holds; decrement at 0 holds. A grant is still issued in both cases.
  - After a grant to r, the pointer becomes (r+1) mod N_REQ. With no grant, the pointer holds.
  - Update latency is one cycle; ta_state reflects the update the cycle after grant.
  - Several requesters targeting the same index: only one is granted per cycle, so updates serialize with no lost updates.
- IDLE, load start:
  - load_start = 1 takes priority over requests: no grant that cycle.
  - On the next edge: load_value is latched, load index = 0, FSM → LOAD, busy = 1.
- LOAD:
  - grant = 0 throughout; requests stay pending.
  - Each cycle writes the latched value into automaton [load index], then increments the index.
  - After the write to index N_TA-1: FSM → IDLE, busy = 0, load_done = 1 for exactly one cycle.
  - Load duration is N_TA cycles. Arbitration resumes the cycle after busy falls, with the pointer unchanged.
  - load_start while in LOAD is ignored.
- ta_action[i] = ta_state[i*STATE_W + STATE_W-1].
- Idle with no requests: all state holds.

Test Plan:
- Reset, then idle 3 cycles → every ta_state slice = 3, ta_action = 8'h00, grant = 0, busy = 0.
- Requester 1 increments TA 5 once (state 3) → grant = 4'b0010; next cycle TA5 = 4, ta_action[5] = 1. Four more increments → TA5 saturates at 7, still granted.
- req = 4'b1111 held, all targeting distinct TAs → grants cycle 0001, 0010, 0100, 1000, 0001. Drop req[2] after its grant → sequence skips 0100.
- Requesters 0 and 3 both decrement TA 2 (state 3) while held 4 cycles → TA2 reaches 0 after 3 grants; the fourth grant holds it at 0.
- load_start with load_value = 6 while req = 4'b0001 → grant = 0 that cycle. busy high 8 cycles; TA0..TA7 written to 6 in order; load_done pulses once. Requester 0 is then granted the cycle after busy falls.
- rst_n low during cycle 4 of a load → after reset all TAs = 3, busy = 0, no load_done pulse.
